// File: rtl/aes_iter_core.sv
// ---------------------------------------------------------------------------
// aes_iter_core
//   Iterative AES encryption core. One cipher round per clock; AES-128/192/256
//   chosen by KEY_BITS. Round keys are read from an external key-schedule store
//   addressed by rk_idx, with a combinational same-cycle return on rk.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   plaintext valid
//   in_ready   out  core can accept plaintext
//   in_text    in   128-bit plaintext, byte 0 at [127:120], column-major
//   rk_idx     out  round-key index requested this cycle (registered)
//   rk         in   round key for rk_idx
//   out_valid  out  ciphertext valid
//   out_ready  in   downstream accepts ciphertext
//   out_text   out  128-bit ciphertext, same byte order as in_text
//   busy       out  high while rounds are being computed
//
// Helper modules in this file: aes_sub_byte, aes_shift_rows, aes_mix_column,
// aes_ark.
// ---------------------------------------------------------------------------

// S-box: multiplicative inverse in GF(2^8) (computed as x^254) followed by the
// AES affine transform. Zero maps to zero before the affine step.
module aes_sub_byte (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  always_comb begin
    // Addition chain for x^254 = x^240 * x^12 * x^2
    x2   = gf_mul(a_i, a_i);
    x3   = gf_mul(x2, a_i);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    y_o  = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end
endmodule

// ShiftRows: byte (row r, column c) takes byte (r, (c+r) mod 4).
module aes_shift_rows (
  input  logic [127:0] d_i,
  output logic [127:0] d_o
);
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
    assign d_o[127-8*gi -: 8] = d_i[127-8*SRC -: 8];
  end
endmodule

// MixColumns on one 32-bit column (row 0 in the top byte).
module aes_mix_column (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign col_o[31:24] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
  assign col_o[15:8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
  assign col_o[7:0]   = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
endmodule

// AddRoundKey.
module aes_ark (
  input  logic [127:0] d_i,
  input  logic [127:0] rk_i,
  output logic [127:0] d_o
);
  assign d_o = d_i ^ rk_i;
endmodule

module aes_iter_core #(
  parameter int KEY_BITS = 256,
  parameter int RIDX_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_text,
  output logic [RIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_text,
  output logic              busy
);
  localparam int NR = (KEY_BITS == 128) ? 10 : (KEY_BITS == 192) ? 12 : 14;

  if ((KEY_BITS != 128) && (KEY_BITS != 192) && (KEY_BITS != 256)) begin : g_bad_key
    $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
  end
  if ((1 << RIDX_W) <= NR) begin : g_bad_ridx
    $error("aes_iter_core: RIDX_W too narrow to index round NR");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RIDX_W-1:0]   rnd_q, rnd_d;
  logic [127:0]        data_q, data_d;
  logic [127:0]        out_text_q, out_text_d;
  logic [RIDX_W-1:0]   rk_idx_q, rk_idx_d;

  logic [127:0]        sb_w, sr_w, mc_w, pre_ark_w, round_w, init_w;
  logic                last_round;

  // ---- Round datapath ----
  for (genvar gi = 0; gi < 16; gi++) begin : g_sb
    aes_sub_byte u_sb (
      .a_i (data_q[127-8*gi -: 8]),
      .y_o (sb_w[127-8*gi -: 8])
    );
  end

  aes_shift_rows u_sr (
    .d_i (sb_w),
    .d_o (sr_w)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_mc
    aes_mix_column u_mc (
      .col_i (sr_w[127-32*gi -: 32]),
      .col_o (mc_w[127-32*gi -: 32])
    );
  end

  assign last_round = (rnd_q == RIDX_W'(NR));
  // The final round has no MixColumns.
  assign pre_ark_w  = last_round ? sr_w : mc_w;

  aes_ark u_ark_round (
    .d_i  (pre_ark_w),
    .rk_i (rk),
    .d_o  (round_w)
  );

  // Initial whitening with round key 0 (rk_idx is 0 whenever a block is accepted).
  aes_ark u_ark_init (
    .d_i  (in_text),
    .rk_i (rk),
    .d_o  (init_w)
  );

  // ---- Control ----
  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    data_d     = data_q;
    out_text_d = out_text_q;
    in_ready   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = init_w;
          rnd_d   = RIDX_W'(1);
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        data_d = round_w;
        if (last_round) begin
          out_text_d = round_w;
          rnd_d      = '0;
          state_d    = ST_DONE;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end
      ST_DONE: begin
        // Downstream acceptance frees the core, so a new block may enter
        // in the same cycle the current one retires.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            data_d  = init_w;
            rnd_d   = RIDX_W'(1);
            state_d = ST_ROUND;
          end else begin
            rnd_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        rnd_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Key address is registered from next-state so the key RAM sees a clean
    // flop output that already matches the round being computed.
    rk_idx_d = (state_d == ST_ROUND) ? rnd_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rnd_q      <= '0;
      data_q     <= '0;
      out_text_q <= '0;
      rk_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      data_q     <= data_d;
      out_text_q <= out_text_d;
      rk_idx_q   <= rk_idx_d;
    end
  end

  assign rk_idx    = rk_idx_q;
  assign out_text  = out_text_q;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ROUND);

endmodule

// File: tb/tb_aes_iter_core.sv
// ---------------------------------------------------------------------------
// tb_aes_iter_core
//   Three cores (AES-128/192/256) share a clock and reset. A behavioural AES
//   model (byte-array state, table S-box, software key expansion) supplies the
//   key store contents and expected ciphertexts for random vectors; the FIPS-197
//   appendix C vectors are checked against their published ciphertexts.
// ---------------------------------------------------------------------------
module tb_aes_iter_core;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [127:0] in_text   [NI];
  logic [3:0]   rk_idx    [NI];
  logic [127:0] rk        [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] out_text  [NI];
  logic         busy      [NI];

  logic [127:0] ks [NI][16];
  logic [7:0]   sbox [256];

  int checks   = 0;
  int failures = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    assign rk[gi] = ks[gi][rk_idx[gi]];
    aes_iter_core #(.KEY_BITS(128 + 64*gi), .RIDX_W(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_text   (in_text[gi]),
      .rk_idx    (rk_idx[gi]),
      .rk        (rk[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_text  (out_text[gi]),
      .busy      (busy[gi])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] mix_coef(input int d);
    case (d)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  // S-box table by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sbox[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // Fill the key store of core k from a key held MSB-first in key[255:...].
  task automatic expand_key(input int k, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    int nr;
    nk = 4 + 2*k;
    nr = 10 + 2*k;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) ks[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         ks[k][r] = '0;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input int k, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   col [4];
    logic [127:0] key;
    logic [127:0] res;
    int nr;
    nr  = 10 + 2*k;
    key = ks[k][0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          t[rw + 4*c] = s[rw + 4*((c + rw) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) col[j] = t[4*c + j];
          for (int rw = 0; rw < 4; rw++) begin
            t[4*c + rw] = 8'h00;
            for (int j = 0; j < 4; j++)
              t[4*c + rw] = t[4*c + rw] ^ gmul(mix_coef((j - rw + 4) % 4), col[j]);
          end
        end
      end
      key = ks[k][r];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ key[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One block through core k with out_ready high; checks exact latency,
  // rk_idx sequence and the retire cycle.
  task automatic run_block(input int k, input logic [127:0] pt, input logic [127:0] expv,
                           input string name);
    int nr;
    nr = 10 + 2*k;
    step();
    chk({name, "_in_ready_idle"}, 128'(in_ready[k]), 128'd1);
    in_valid[k]  = 1'b1;
    in_text[k]   = pt;
    out_ready[k] = 1'b1;
    step();
    in_valid[k] = 1'b0;
    in_text[k]  = {$urandom, $urandom, $urandom, $urandom};
    for (int r = 1; r <= nr; r++) begin
      chk($sformatf("%s_rk_idx_r%0d", name, r), 128'(rk_idx[k]), 128'(r));
      chk($sformatf("%s_busy_r%0d", name, r), 128'({busy[k], out_valid[k]}), 128'b10);
      step();
    end
    chk({name, "_out_valid_at_nr"}, 128'(out_valid[k]), 128'd1);
    chk({name, "_out_text"}, out_text[k], expv);
    chk({name, "_done_rk_idx"}, 128'(rk_idx[k]), 128'd0);
    step();
    chk({name, "_retired"}, 128'({out_valid[k], in_ready[k], busy[k]}), 128'b010);
  endtask

  initial begin
    logic [127:0] pt;
    logic [127:0] pt_b;
    logic [127:0] exp_a;
    logic [127:0] exp_b;
    logic [255:0] key;
    int n;

    pt = 128'h00112233445566778899aabbccddeeff;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      in_text[k]   = '0;
      out_ready[k] = 1'b1;
    end
    build_sbox();
    expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    expand_key(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    expand_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

    // Reset state
    step();
    step();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset_flags_%0d", k),
          128'({in_ready[k], out_valid[k], busy[k]}), 128'b100);
      chk($sformatf("reset_rk_idx_%0d", k), 128'(rk_idx[k]), 128'd0);
      chk($sformatf("reset_out_text_%0d", k), out_text[k], 128'd0);
    end
    #2 rst = 1'b0;

    // FIPS-197 appendix C vectors
    run_block(0, pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "c1_aes128");
    run_block(1, pt, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "c2_aes192");
    run_block(2, pt, 128'h8ea2b7ca516745bfeafc49904b496089, "c3_aes256");

    // Random keys and plaintexts against the model
    for (int k = 0; k < NI; k++) begin
      for (int it = 0; it < 3; it++) begin
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        expand_key(k, key);
        pt_b = {$urandom, $urandom, $urandom, $urandom};
        run_block(k, pt_b, ref_encrypt(k, pt_b), $sformatf("rand_k%0d_%0d", k, it));
      end
    end

    // Backpressure on the AES-128 core: 20 stalled cycles, in_valid held high
    pt_b  = {$urandom, $urandom, $urandom, $urandom};
    exp_a = ref_encrypt(0, pt_b);
    step();
    in_valid[0]  = 1'b1;
    in_text[0]   = pt_b;
    out_ready[0] = 1'b0;
    step();
    in_text[0] = ~pt_b;
    n = 0;
    while (!out_valid[0] && n < 50) begin
      step();
      n++;
    end
    chk("bp_latency", 128'(n), 128'd10);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("bp_text_c%0d", i), out_text[0], exp_a);
      chk($sformatf("bp_flags_c%0d", i),
          128'({out_valid[0], in_ready[0], busy[0]}), 128'b100);
      step();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    step();
    chk("bp_release", 128'({out_valid[0], in_ready[0], busy[0]}), 128'b010);

    // Back-to-back on the AES-192 core
    pt   = {$urandom, $urandom, $urandom, $urandom};
    pt_b = {$urandom, $urandom, $urandom, $urandom};
    exp_a = ref_encrypt(1, pt);
    exp_b = ref_encrypt(1, pt_b);
    step();
    in_valid[1]  = 1'b1;
    in_text[1]   = pt;
    out_ready[1] = 1'b1;
    step();
    in_text[1] = pt_b;
    n = 0;
    while (!out_valid[1] && n < 50) begin
      step();
      n++;
    end
    chk("b2b_latency_a", 128'(n), 128'd12);
    chk("b2b_text_a", out_text[1], exp_a);
    chk("b2b_in_ready_done", 128'(in_ready[1]), 128'd1);
    step();
    in_valid[1] = 1'b0;
    chk("b2b_handoff", 128'({out_valid[1], busy[1], rk_idx[1]}), 128'({2'b01, 4'd1}));
    n = 1;
    while (!out_valid[1] && n < 50) begin
      step();
      n++;
    end
    chk("b2b_spacing", 128'(n), 128'd13);
    chk("b2b_text_b", out_text[1], exp_b);
    step();
    chk("b2b_retire_b", 128'({out_valid[1], in_ready[1]}), 128'b01);

    // Reset in the middle of round 5, then C.1 again
    expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    pt = {$urandom, $urandom, $urandom, $urandom};
    step();
    in_valid[0] = 1'b1;
    in_text[0]  = pt;
    step();
    in_valid[0] = 1'b0;
    repeat (4) step();
    chk("rst_mid_round5", 128'(rk_idx[0]), 128'd5);
    rst = 1'b1;
    #1;
    chk("rst_mid_flags", 128'({out_valid[0], in_ready[0], busy[0]}), 128'b010);
    chk("rst_mid_rk_idx", 128'(rk_idx[0]), 128'd0);
    #2 rst = 1'b0;
    run_block(0, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, "c1_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
